// File: rtl/register_bank.sv
// PDUA register bank: eight working registers feeding the ALU operand buses,
// plus the MAR/MDR pair that faces external memory.
module register_bank #(
  parameter int                   MAX_WIDTH = 8,
  parameter logic [MAX_WIDTH-1:0] SP_INIT   = 8'hFF,
  parameter logic [MAX_WIDTH-1:0] VI_INIT   = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAX_WIDTH-1:0] busC,
  input  logic [2:0]           selC,
  input  logic                 wrC,
  input  logic [2:0]           selB,
  input  logic                 mar_ld,
  input  logic                 mdr_ld,
  input  logic [MAX_WIDTH-1:0] mem_rdata,
  output logic [MAX_WIDTH-1:0] busA,
  output logic [MAX_WIDTH-1:0] busB,
  output logic [MAX_WIDTH-1:0] mem_addr,
  output logic [MAX_WIDTH-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    REG_PC   = 3'd0,
    REG_SP   = 3'd1,
    REG_DPTR = 3'd2,
    REG_A    = 3'd3,
    REG_VI   = 3'd4,
    REG_TEMP = 3'd5,
    REG_MDR  = 3'd6,
    REG_ACC  = 3'd7
  } reg_idx_e;

  logic [MAX_WIDTH-1:0] regs_q [8];
  logic [MAX_WIDTH-1:0] regs_d [8];
  logic [MAX_WIDTH-1:0] mar_q;
  logic [MAX_WIDTH-1:0] mar_d;

  always_comb begin
    // NOTE: every register defaults to its current value first, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    regs_d = regs_q;
    mar_d  = mar_q;
    if (wrC) regs_d[selC] = busC;
    // Memory data wins over a same-cycle ALU write-back into MDR.
    if (mdr_ld) regs_d[REG_MDR] = mem_rdata;
    if (mar_ld) mar_d = busC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is small and architecturally visible, so each
      // entry gets a defined reset value rather than being left uninitialised.
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      regs_q[REG_SP] <= SP_INIT;
      regs_q[REG_VI] <= VI_INIT;
      mar_q          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      regs_q <= regs_d;
      mar_q  <= mar_d;
    end
  end

  // Reads come straight from state: a same-cycle write shows up next cycle.
  assign busA      = regs_q[REG_ACC];
  assign busB      = regs_q[selB];
  assign mem_addr  = mar_q;
  assign mem_wdata = regs_q[REG_MDR];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed vectors with literal
// expectations, plus an array-based reference model compared every cycle.
module tb_register_bank;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] busC;
  logic [2:0]   selC;
  logic         wrC;
  logic [2:0]   selB;
  logic         mar_ld;
  logic         mdr_ld;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] busA;
  logic [W-1:0] busB;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;

  register_bank #(.MAX_WIDTH(W), .SP_INIT(8'hFF), .VI_INIT(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .busC      (busC),
    .selC      (selC),
    .wrC       (wrC),
    .selB      (selB),
    .mar_ld    (mar_ld),
    .mdr_ld    (mdr_ld),
    .mem_rdata (mem_rdata),
    .busA      (busA),
    .busB      (busB),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register file as a plain array, MAR as a variable.
  logic [W-1:0] m_reg [8];
  logic [W-1:0] m_mar;
  bit           model_valid = 1'b0;

  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one rising edge, apply the architectural rules to the model using
  // the inputs that were presented during the cycle, then step off the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_reg[1] = 8'hFF;
      m_reg[4] = 8'h00;
      m_mar    = '0;
      model_valid = 1'b1;
    end else begin
      if (wrC)    m_reg[selC] = busC;
      if (mdr_ld) m_reg[6]    = mem_rdata;
      if (mar_ld) m_mar       = busC;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wrC = 1'b0; mar_ld = 1'b0; mdr_ld = 1'b0;
  endtask

  // Every cycle, away from the rising edge, outputs must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("model_busA", busA, m_reg[7]);
        check("model_busB", busB, m_reg[selB]);
        check("model_mem_addr", mem_addr, m_mar);
        check("model_mem_wdata", mem_wdata, m_reg[6]);
      end
    end
  end

  logic [W-1:0] reset_tbl [8];

  initial begin
    reset_tbl = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_mar = '0;

    // Reset overrides a same-cycle ACC write.
    rst = 1'b1; wrC = 1'b1; selC = 3'd7; busC = 8'h55;
    mar_ld = 1'b0; mdr_ld = 1'b0; mem_rdata = '0; selB = 3'd0;
    tick();
    idle_inputs();
    #1;
    check("rst_busA", busA, 8'h00);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    for (int i = 0; i < 8; i++) begin
      selB = 3'(i);
      #1;
      check($sformatf("rst_busB_%0d", i), busB, reset_tbl[i]);
    end

    // Write then read back every index; ACC only changes on the index-7 write.
    for (int i = 0; i < 8; i++) begin
      selC = 3'(i); busC = 8'h10 + 8'(i); wrC = 1'b1;
      tick();
      wrC = 1'b0; selB = 3'(i);
      #1;
      check($sformatf("wr_busB_%0d", i), busB, 8'h10 + 8'(i));
      check($sformatf("wr_busA_%0d", i), busA, (i == 7) ? 8'h17 : 8'h00);
    end

    // Read-during-write returns old data in the write cycle.
    selC = 3'd3; busC = 8'h3C; wrC = 1'b1;
    tick();
    selB = 3'd3; selC = 3'd3; busC = 8'hA5; wrC = 1'b1;
    #1;
    check("rdw_old", busB, 8'h3C);
    tick();
    wrC = 1'b0;
    #1;
    check("rdw_new", busB, 8'hA5);

    // MDR load beats a same-cycle busC write to MDR.
    selC = 3'd6; wrC = 1'b1; busC = 8'h11; mdr_ld = 1'b1; mem_rdata = 8'h99;
    tick();
    idle_inputs(); selB = 3'd6;
    #1;
    check("mdr_prio_wdata", mem_wdata, 8'h99);
    check("mdr_prio_busB", busB, 8'h99);

    // Memory read sequence: MAR, then MDR, then readable on busB.
    mar_ld = 1'b1; busC = 8'h40;
    tick();
    mar_ld = 1'b0;
    #1;
    check("seq_mem_addr", mem_addr, 8'h40);
    mdr_ld = 1'b1; mem_rdata = 8'h7E;
    tick();
    mdr_ld = 1'b0; selB = 3'd6;
    #1;
    check("seq_busB_mdr", busB, 8'h7E);
    selB = 3'd3;
    #1;
    check("seq_A_untouched", busB, 8'hA5);

    // One busC value into a register and MAR together.
    selC = 3'd2; busC = 8'h33; wrC = 1'b1; mar_ld = 1'b1;
    tick();
    idle_inputs(); selB = 3'd2;
    #1;
    check("dual_mem_addr", mem_addr, 8'h33);
    check("dual_busB", busB, 8'h33);

    // Hold, then reset aborts a MAR load.
    selC = 3'd7; busC = 8'hF0; wrC = 1'b1;
    tick();
    wrC = 1'b0;
    repeat (3) tick();
    check("hold_busA", busA, 8'hF0);
    rst = 1'b1; mar_ld = 1'b1; busC = 8'h22;
    tick();
    idle_inputs();
    #1;
    check("midrst_mem_addr", mem_addr, 8'h00);
    check("midrst_busA", busA, 8'h00);

    // Mixed traffic checked only against the model.
    for (int n = 0; n < 60; n++) begin
      rst       = ($urandom_range(0, 19) == 0);
      wrC       = 1'($urandom);
      mar_ld    = 1'($urandom);
      mdr_ld    = 1'($urandom);
      selC      = 3'($urandom);
      selB      = 3'($urandom);
      busC      = 8'($urandom);
      mem_rdata = 8'($urandom);
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Register bank for the PDUA datapath, directly upstream of the ALU. It holds the eight architectural/working registers and drives the ALU operands: `busA` is always the accumulator, and `busB` is one register selected by the microinstruction. It captures the ALU output `busC` into a selected register, and owns the memory address register (MAR). Its memory data register (MDR) loads from external memory.

## Interface
- `MAX_WIDTH`, default 8: data width of every register and bus.
- `SP_INIT`, default 8'hFF: stack pointer value after reset.
- `VI_INIT`, default 8'h00: interrupt vector register value after reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `busC` input MAX_WIDTH: ALU result, write-back data.
- `selC` input 3: destination register index for the `busC` write.
- `wrC` input 1: write enable for `busC` into register `selC`.
- `selB` input 3: source register index driven onto `busB`.
- `mar_ld` input 1: load MAR from `busC`.
- `mdr_ld` input 1: load MDR from `mem_rdata`.
- `mem_rdata` input MAX_WIDTH: read data from memory.
- `busA` output MAX_WIDTH: always the value of ACC.
- `busB` output MAX_WIDTH: value of register `selB`.
- `mem_addr` output MAX_WIDTH: current MAR value.
- `mem_wdata` output MAX_WIDTH: current MDR value.

## Operation
Register map, by 3-bit index:
- 0 = PC
- 1 = SP
- 2 = DPTR
- 3 = A
- 4 = VI
- 5 = TEMP
- 6 = MDR
- 7 = ACC

Write rules:
- `wrC`=1: register[`selC`] <= `busC` at the clock edge. All indices are writable, including MDR.
- `mdr_ld`=1: MDR <= `mem_rdata`.
- `mdr_ld` has priority over `wrC` when `selC`=6 in the same cycle. The `busC` write is dropped.
- `mar_ld`=1: MAR <= `busC`. This is independent of `wrC`, so a `busC` value may go to a register and MAR in the same cycle.
- No enable asserted: all registers hold.

Read rules:
- `busA` and `busB` are combinational reads of register contents, with no output register.
- `busB` = register[`selB`].
- Read-during-write to the same index returns the old value in that cycle and the new value from the next cycle. There is no write-through bypass.

Reset (synchronous, while `rst`=1 at a rising edge):
- SP = `SP_INIT`, VI = `VI_INIT`.
- PC, DPTR, A, TEMP, MDR, ACC and MAR = 0.
- Reset overrides `wrC`, `mdr_ld` and `mar_ld` asserted in the same cycle.

Output values after reset:
- `busA` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- `busB` = the reset value of register `selB`.

Width rules:
- All values are full MAX_WIDTH, with no extension or truncation.
- `selB`/`selC` decode covers all 8 codes, so there are no illegal indices.

## Timing
- Write latency: 1 cycle. Data presented with an enable in cycle n is visible on `busA`/`busB`/`mem_addr`/`mem_wdata` in cycle n+1.
- Read latency: 0 cycles, combinational from the register state and `selB`.
- ALU loop: `busA`/`busB` (cycle n) -> ALU -> `busC` -> written at the end of cycle n. A microinstruction can therefore read, operate and write back in a single cycle, e.g. ACC <= ACC + A.
- Memory read sequence:
  - cycle 0: `mar_ld` sets MAR.
  - memory returns `mem_rdata` in the following cycle.
  - cycle 1: `mdr_ld` captures it.
  - cycle 2: MDR is readable on `busB` with `selB`=6.
- Memory write: `mem_wdata`/`mem_addr` reflect MDR/MAR continuously. The memory write strobe is owned by the control unit.
- Reset asserted mid-sequence aborts the operation in progress. There are no partial updates.

## Test plan
- Reset values: assert `rst` for 1 cycle with `wrC`=1, `selC`=7, `busC`=8'h55 -> ACC=0, SP=8'hFF, VI=8'h00, `busA`=0, `mem_addr`=0. Sweep `selB` 0..7 -> read values {0,FF,0,0,0,0,0,0}.
- Write/read all registers: write `busC`=8'h10+i to each index i -> next cycle `busB` with `selB`=i reads 8'h10+i. `busA` reads 8'h17 only after the index-7 write.
- Read-during-write: `selB`=3, `selC`=3, `wrC`=1, `busC`=8'hA5, A previously 8'h3C -> `busB`=8'h3C that cycle, 8'hA5 next cycle.
- MDR priority: `selC`=6, `wrC`=1, `busC`=8'h11, `mdr_ld`=1, `mem_rdata`=8'h99 -> MDR=8'h99 and `mem_wdata`=8'h99.
- MAR/memory sequence: `mar_ld`=1 with `busC`=8'h40, then `mdr_ld`=1 with `mem_rdata`=8'h7E -> `mem_addr`=8'h40 from the next cycle. With `selB`=6, `busB`=8'h7E one cycle after the load. With `wrC`=0, no other register changes.
- Hold and mid-operation reset: write ACC=8'hF0, idle 3 cycles -> `busA` stays 8'hF0. Then assert `rst` together with `mar_ld`=1 and `busC`=8'h22 -> MAR=0 and ACC=0 on the next cycle.
